// File: rtl/uart_pkg.sv
// Shared UART definitions: the state encoding is common to the transmitter and
// the UART_RX receiver so both debug outputs decode the same way on GPIO.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_sm_t;

  localparam int UART_CLKS_PER_BIT_115200 = 434;
  localparam int UART_DATA_BITS           = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with first-word-fall-through read. The extra pointer bit tells a
// full FIFO apart from an empty one when the index bits are equal.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a bit-timing state machine
// that sends frames LSB-first, back-to-back whenever the FIFO has data.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_Ready,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done,
  output logic       o_Overflow,
  output logic [1:0] o_SM_Main
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  uart_sm_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             cnt_last;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (i_TX_Byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ready is judged before any same-cycle pop, so a full FIFO rejects the write.
  assign o_Ready     = !fifo_full;
  assign fifo_push   = i_TX_DV && !fifo_full;
  assign cnt_last    = (cnt_q == CNT_LAST);
  assign o_TX_Serial = ser_q;
  assign o_TX_Active = (state_q != IDLE);
  assign o_TX_Done   = done_q;
  assign o_Overflow  = ovf_q;
  assign o_SM_Main   = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    ser_d    = ser_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    ovf_d    = ovf_q | (i_TX_DV & fifo_full);

    case (state_q)
      IDLE: begin
        ser_d = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          ser_d    = 1'b0;
          state_d  = START;
        end
      end

      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          ser_d   = sh_q[0];
          sh_d    = sh_q >> 1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            ser_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
            ser_d = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        // Registered pulse lands on the final clock of the stop bit.
        done_d = (cnt_q == CNT_PRE);
        if (cnt_last) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = fifo_dout;
            ser_d    = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    sh_q <= sh_d;
    if (reset_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: written bytes go to a scoreboard queue and a line
// monitor decodes every frame cycle by cycle against the head of that queue.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk_clk     = 1'b0;
  logic       reset_reset = 1'b1;
  logic       i_TX_DV     = 1'b0;
  logic [7:0] i_TX_Byte   = 8'h00;
  logic       o_Ready;
  logic       o_TX_Serial;
  logic       o_TX_Active;
  logic       o_TX_Done;
  logic       o_Overflow;
  logic [1:0] o_SM_Main;

  int         checks      = 0;
  int         errors      = 0;
  int         cyc         = 0;
  int         frames_seen = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         mon_abort   = 1'b1;
  bit         ovf_exp     = 1'b0;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .i_TX_DV     (i_TX_DV),
    .i_TX_Byte   (i_TX_Byte),
    .o_Ready     (o_Ready),
    .o_TX_Serial (o_TX_Serial),
    .o_TX_Active (o_TX_Active),
    .o_TX_Done   (o_TX_Done),
    .o_Overflow  (o_Overflow),
    .o_SM_Main   (o_SM_Main)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called on the negedge where the start bit is first seen.
  task automatic monitor_frame();
    logic [7:0] b;
    logic       exp_bit;
    logic [1:0] exp_sm;
    start_q.push_back(cyc);
    if (exp_q.size() == 0) begin
      check_eq("unexpected_frame", 1, 0);
      b = 8'h00;
    end else begin
      b = exp_q.pop_front();
    end
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        if (k != 0 || j != 0) @(negedge clk_clk);
        if (mon_abort) return;
        exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        exp_sm  = (k == 0) ? 2'd1 : (k == 9) ? 2'd3 : 2'd2;
        check_eq("tx_bit", o_TX_Serial, exp_bit);
        check_eq("sm_state", o_SM_Main, exp_sm);
        check_eq("active", o_TX_Active, 1);
        check_eq("done_pulse", o_TX_Done, (k == 9 && j == CPB - 1));
      end
    end
    frames_seen++;
  endtask

  initial begin
    forever begin
      @(negedge clk_clk);
      if (!mon_abort && o_TX_Serial === 1'b0) monitor_frame();
    end
  end

  // Caller is positioned at a negedge; the write is sampled on the next posedge.
  task automatic drive_byte(input logic [7:0] b, input bit accept);
    check_eq("ready_before_write", o_Ready, accept);
    i_TX_DV   = 1'b1;
    i_TX_Byte = b;
    if (accept) exp_q.push_back(b);
    else        ovf_exp = 1'b1;
    @(posedge clk_clk);
    #1;
    i_TX_DV = 1'b0;
    check_eq("overflow_flag", o_Overflow, ovf_exp);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accept);
    @(negedge clk_clk);
    drive_byte(b, accept);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n = 0;
    do begin
      @(negedge clk_clk);
      n++;
    end while (!(exp_q.size() == 0 && o_SM_Main == 2'd0) && n < max_cyc);
    check_eq(tag, (n < max_cyc), 1);
  endtask

  task automatic idle_check(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk_clk);
      check_eq("idle_line", o_TX_Serial, 1);
      check_eq("idle_done", o_TX_Done, 0);
      check_eq("idle_sm", o_SM_Main, 0);
      check_eq("idle_active", o_TX_Active, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;

    // Reset
    reset_reset = 1'b1;
    @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
    check_eq("rst_serial", o_TX_Serial, 1);
    check_eq("rst_ready", o_Ready, 1);
    check_eq("rst_sm", o_SM_Main, 0);
    check_eq("rst_active", o_TX_Active, 0);
    check_eq("rst_done", o_TX_Done, 0);
    check_eq("rst_overflow", o_Overflow, 0);
    mon_abort = 1'b0;

    // Single byte with one-cycle write-to-line latency
    base = frames_seen;
    @(negedge clk_clk);
    drive_byte(8'hA5, 1'b1);
    check_eq("lat_line_n", o_TX_Serial, 1);
    check_eq("lat_sm_n", o_SM_Main, 0);
    @(posedge clk_clk);
    #1;
    check_eq("lat_line_n1", o_TX_Serial, 0);
    check_eq("lat_active_n1", o_TX_Active, 1);
    wait_idle(200, "single_idle");
    idle_check(8);
    check_eq("single_frames", frames_seen - base, 1);

    // Burst of three on consecutive cycles
    base = start_q.size();
    write_byte(8'h00, 1'b1);
    write_byte(8'hFF, 1'b1);
    write_byte(8'h3C, 1'b1);
    wait_idle(400, "burst_idle");
    check_eq("burst_frames", start_q.size() - base, 3);
    if (start_q.size() >= base + 3) begin
      for (int i = 1; i < 3; i++)
        check_eq("burst_gap", start_q[base+i] - start_q[base+i-1], FRAME);
    end
    idle_check(4);

    // Overflow: fill the FIFO behind an active frame
    base = frames_seen;
    write_byte(8'h11, 1'b1);
    repeat (3) @(negedge clk_clk);
    for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h20 + i), 1'b1);
    check_eq("ovf_ready_low", o_Ready, 0);
    write_byte(8'h28, 1'b0);
    wait_idle(600, "ovf_idle");
    check_eq("ovf_frames", frames_seen - base, 9);
    check_eq("ovf_sticky", o_Overflow, 1);
    idle_check(4);

    // Push on the pop edge at the end of a stop bit
    base = frames_seen;
    write_byte(8'hC3, 1'b1);
    repeat (3) @(negedge clk_clk);
    write_byte(8'h96, 1'b1);
    n = 0;
    do begin
      @(negedge clk_clk);
      n++;
    end while (o_TX_Done !== 1'b1 && n < 100);
    check_eq("sim_done_seen", (n < 100), 1);
    drive_byte(8'h4B, 1'b1);
    for (int i = 0; i < 6; i++) write_byte(8'(8'h60 + i), 1'b1);
    check_eq("sim_ready_at7", o_Ready, 1);
    write_byte(8'h66, 1'b1);
    check_eq("sim_ready_at8", o_Ready, 0);
    wait_idle(700, "sim_idle");
    check_eq("sim_frames", frames_seen - base, 10);
    idle_check(4);

    // Reset during DATA bit 3 with bytes still queued
    write_byte(8'h5A, 1'b1);
    write_byte(8'h77, 1'b1);
    write_byte(8'h12, 1'b1);
    n = 0;
    do begin
      @(negedge clk_clk);
      n++;
    end while (o_SM_Main !== 2'd2 && n < 50);
    check_eq("rmf_data_seen", (n < 50), 1);
    repeat (3 * CPB + 1) @(negedge clk_clk);
    check_eq("rmf_in_data", o_SM_Main, 2);
    mon_abort   = 1'b1;
    reset_reset = 1'b1;
    @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
    ovf_exp     = 1'b0;
    exp_q.delete();
    check_eq("rmf_line", o_TX_Serial, 1);
    check_eq("rmf_ready", o_Ready, 1);
    check_eq("rmf_sm", o_SM_Main, 0);
    check_eq("rmf_done", o_TX_Done, 0);
    check_eq("rmf_overflow", o_Overflow, 0);
    idle_check(100);
    mon_abort = 1'b0;

    // Recovery after reset
    base = frames_seen;
    write_byte(8'hE7, 1'b1);
    wait_idle(200, "recover_idle");
    check_eq("recover_frames", frames_seen - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered 8N1 UART transmitter: the transmit counterpart to the existing `UART_RX` receiver, driving the same GPIO serial link. A small byte FIFO accepts bytes from fabric logic. A bit-timing state machine serialises them LSB-first at `CLKS_PER_BIT` clocks per bit, back-to-back with no idle gap between frames. It exposes a 2-bit state debug output matching the receiver's `o_SM_Main` so both ends can be probed on GPIO.

## Interface
- `CLKS_PER_BIT`, 434, clocks per serial bit (50 MHz / 115200); must be ≥ 2
- `FIFO_DEPTH`, 8, byte FIFO entries; power of two, ≥ 2
- `clk_clk`  in  1  system clock; the single clock for all logic
- `reset_reset`  in  1  reset: synchronous, active-high; one clock; all state cleared on the edge where it is sampled high
- `i_TX_DV`  in  1  write strobe; the byte is accepted on a clock edge where `i_TX_DV=1` and `o_Ready=1`
- `i_TX_Byte`  in  8  byte to send, sampled with `i_TX_DV`
- `o_Ready`  out  1  FIFO not full; combinational from FIFO count
- `o_TX_Serial`  out  1  serial line, registered; idle high
- `o_TX_Active`  out  1  high while a frame is on the line (states START/DATA/STOP)
- `o_TX_Done`  out  1  one-cycle pulse on the last clock of each stop bit
- `o_Overflow`  out  1  sticky; set when `i_TX_DV=1` while `o_Ready=0`; cleared only by reset
- `o_SM_Main`  out  2  current state encoding

## Operation
- States are `IDLE`=0, `START`=1, `DATA`=2, `STOP`=3.
- **Reset values:**
  - state `IDLE`
  - `o_TX_Serial=1`, `o_TX_Active=0`, `o_TX_Done=0`, `o_Overflow=0`
  - FIFO empty, so `o_Ready=1`
  - bit counter 0, clock counter 0
- **IDLE:** if the FIFO is non-empty, pop the head into the shift register, drive `o_TX_Serial=0` and go to `START`. Otherwise hold the line high.
- **START:** hold the line low for `CLKS_PER_BIT` clocks, then drive bit 0 and go to `DATA`.
- **DATA:**
  - Each bit is held `CLKS_PER_BIT` clocks; bits are sent LSB first, bit index 0..7.
  - After bit 7 completes, drive the line high and go to `STOP`.
- **STOP:** hold the line high for `CLKS_PER_BIT` clocks. On the last clock, pulse `o_TX_Done`. On the next edge:
  - if the FIFO is non-empty, pop and go directly to `START` (no idle cycles);
  - otherwise go to `IDLE`.
- **Clock counter:** `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on every bit boundary.
- **Simultaneous push and pop:**
  - Allowed; the FIFO count is unchanged.
  - When the FIFO is full, a push in the same cycle as a pop is still rejected, because `o_Ready` is evaluated before the pop.
- **Rejected writes:** dropped entirely; FIFO contents are untouched and `o_Overflow` is set.
- **Reset mid-frame:** the frame is aborted, the line goes high on the following cycle, FIFO contents are discarded and no `o_TX_Done` pulse is issued.

## Timing
- **Write to line:** a write accepted at edge N into an empty FIFO while `IDLE` gives `o_TX_Serial=0` after edge N+1 (one-cycle latency).
- **Frame length:** exactly 10×`CLKS_PER_BIT` clocks, start bit falling edge to end of stop bit.
- **Back-to-back frames:** the next start bit begins on the clock immediately after the previous stop bit's last clock.
- **`o_TX_Active`:** rises together with the start bit; falls only when the state returns to `IDLE`.
- **FIFO:** read is first-word-fall-through into the shift register; it adds no latency beyond the pop edge.
- **`o_SM_Main`:** registered; updates on the same edge as the state register.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_sm_t` (`IDLE`/`START`/`DATA`/`STOP`, 2 bits), also used by `UART_RX`
  - constant `UART_CLKS_PER_BIT_115200 = 434`
  - constant `UART_DATA_BITS = 8`
- Sub-module `uart_tx_fifo`: synchronous FIFO with parameter `DEPTH` and width 8. Ports: push, pop, din, dout, full, empty. Pointers are `$clog2(DEPTH)+1` bits so full and empty are distinguished by the wrap bit.

## Test plan
Use `CLKS_PER_BIT=4` for all cases below.
- **Reset:** assert reset for 1 clock → `o_TX_Serial=1`, `o_Ready=1`, `o_SM_Main=0`, `o_TX_Active=0`.
- **Single byte:** write `0xA5` while idle → line low 4 clocks, then data bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks. `o_TX_Done` pulses once at clock 40 of the frame; the line then stays high in `IDLE`.
- **Burst:** write `0x00`, `0xFF`, `0x3C` on consecutive cycles → three contiguous 40-clock frames with no idle gap between them and three `o_TX_Done` pulses 40 clocks apart.
- **Overflow:** while frame 1 is active, write 9 more bytes with `FIFO_DEPTH=8` → `o_Ready` drops after the 8th write and the 9th write is dropped. `o_Overflow=1` and stays set. Exactly 9 frames are transmitted in total.
- **Simultaneous push and pop:** with the FIFO holding 1 byte, push on the pop edge at the end of a stop bit → count stays 1, and both bytes are later sent in order.
- **Reset mid-frame:** assert reset during `DATA` bit 3 → line high next cycle, no `o_TX_Done` pulse, queued bytes are never transmitted, `o_Ready=1`.
